ysyx_25040111_arbiter: RTL and testbench
========================================

YSYX_25040111_ARBITER -- requirements
Module: ysyx_25040111_arbiter

Interface
REQ-001 SHALL have parameter AW, 32, address width for all address channels.
REQ-002 SHALL have parameter DW, 32, data width for all data channels.
REQ-003 SHALL have one clock and an asynchronous active-high reset; ports: clk  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-004 SHALL expose ifu_ar{valid,ready,addr,len[7:0],size[2:0]}  in/out  1/1/AW/8/3  IFU read-address channel (ready is the output).
REQ-005 SHALL expose ifu_r{valid,ready,data,resp[1:0],last}  out/in/out/out/out  1/1/DW/2/1  IFU read-data channel.
REQ-006 SHALL expose lsu_ar{valid,ready,addr,len,size}  in/out  1/1/AW/8/3  LSU read-address channel (ready is the output).
REQ-007 SHALL expose lsu_r{valid,ready,data,resp,last}  out/in/out/out/out  1/1/DW/2/1  LSU read-data channel.
REQ-008 SHALL expose lsu_aw{valid,ready,addr,size}, lsu_w{valid,ready,data,strb[3:0],last}, lsu_b{valid,ready,resp}  AXI4 directions  LSU write channels.
REQ-009 SHALL expose a single downstream io_master_* AXI4 master port (aw/w/b/ar/r, ids tied 4'b0, arburst = |arlen ? INCR : FIXED).

Function
REQ-010 SHALL implement FSM states IDLE, IFU_RD, LSU_RD, LSU_WR.
REQ-011 SHALL, in IDLE, grant at the clock edge where any of ifu_arvalid, lsu_arvalid, lsu_awvalid is high; the grant is registered, so io_master_*valid appears 1 cycle after the request is first sampled.
REQ-012 SHALL, with fixed priority, rank LSU write > LSU read > IFU read.
REQ-013 SHALL, while granted, pass valid/addr/len/size/data/strb through combinationally from the granted requester, and pass ready/data/resp/last back to that requester only; non-granted ready/valid outputs SHALL be 0.
REQ-014 SHALL leave IFU_RD/LSU_RD for IDLE on the cycle after io_master_rvalid & rready & rlast.
REQ-015 SHALL leave LSU_WR for IDLE on the cycle after io_master_bvalid & bready.
REQ-016 SHALL, on a new request arriving during a granted transaction, hold it pending (its ready stays 0) until IDLE re-arbitrates.
REQ-017 SHALL forward nonzero rresp/bresp unchanged to the owner and still end the transaction normally.
REQ-018 SHALL track AR and AW acceptance with internal "addr_done" flags so a requester holding valid after ready is never forwarded twice.
REQ-019 SHALL, for bursts, count R beats in an 8-bit counter; an rlast arriving before beat arlen+1 SHALL still end the transaction.

Reset
REQ-020 SHALL, on reset assertion at any time (including mid-burst), go to IDLE, clear addr_done flags, beat counter and RR pointer, and drive every valid/ready output to 0 asynchronously.
REQ-021 SHALL drive all data/addr outputs to 0 while in IDLE.

Configuration
REQ-022 SHALL, with ARB_ROUND_ROBIN_EN defined, replace REQ-012 for reads with round-robin between IFU and LSU (last-served read master loses ties); writes keep top priority.
REQ-023 SHALL, without ARB_ROUND_ROBIN_EN, use fixed priority per REQ-012 and contain no RR pointer register.

Structure
REQ-024 SHALL take state encodings, AXI burst/resp constants (FIXED=2'b00, INCR=2'b01, OKAY=2'b00) from HDR/ysyx_25040111_inc.vh.
REQ-025 SHALL keep the read/write channel mux in one sub-module, ysyx_25040111_axi_mux, with the FSM in the top.

Verification
REQ-026 SHALL cover IFU read alone: ifu_araddr=0x3000_0000, len=0 -> io_master_araddr=0x3000_0000 one cycle later; ifu_rdata returns 0xDEADBEEF; back to IDLE.
REQ-027 SHALL cover same-cycle IFU read and LSU read: fixed priority -> LSU served first, IFU arready held 0 until LSU rlast, then IFU granted.
REQ-028 SHALL cover LSU write with wstrb=4'b0011, wdata=0x0000_1234 -> downstream sees identical strb/data; lsu_bresp=OKAY; FSM returns to IDLE.
REQ-029 SHALL cover IFU burst arlen=3 with reset asserted after beat 2 -> all valid/ready outputs 0 immediately, FSM IDLE, next request served cleanly.
REQ-030 SHALL cover ARB_ROUND_ROBIN_EN with both read masters continuously requesting -> grants alternate IFU, LSU, IFU, LSU.
REQ-031 SHALL cover io_master_rresp=2'b10 on an LSU read -> lsu_rresp=2'b10 and the transaction completes.

Source files
------------

// File: rtl/ysyx_25040111_arbiter_pkg.sv
// Shared types and AXI constants for the IFU/LSU arbiter.
// FSM state encoding plus burst/response codes.
package ysyx_25040111_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } arb_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  function automatic logic [1:0] ar_burst(input logic [7:0] len);
    return (|len) ? BURST_INCR : BURST_FIXED;
  endfunction

endpackage

// File: rtl/ysyx_25040111_axi_mux.sv
// Channel mux: routes the granted requester to the AXI master
// port and returns responses to that requester only.
module ysyx_25040111_axi_mux
  import ysyx_25040111_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  arb_state_e        state_i,
  input  logic              ar_done_i,
  input  logic              aw_done_i,
  input  logic              ifu_arvalid_i,
  output logic              ifu_arready_o,
  input  logic [AW-1:0]     ifu_araddr_i,
  input  logic [7:0]        ifu_arlen_i,
  input  logic [2:0]        ifu_arsize_i,
  output logic              ifu_rvalid_o,
  input  logic              ifu_rready_i,
  output logic [DW-1:0]     ifu_rdata_o,
  output logic [1:0]        ifu_rresp_o,
  output logic              ifu_rlast_o,
  input  logic              lsu_arvalid_i,
  output logic              lsu_arready_o,
  input  logic [AW-1:0]     lsu_araddr_i,
  input  logic [7:0]        lsu_arlen_i,
  input  logic [2:0]        lsu_arsize_i,
  output logic              lsu_rvalid_o,
  input  logic              lsu_rready_i,
  output logic [DW-1:0]     lsu_rdata_o,
  output logic [1:0]        lsu_rresp_o,
  output logic              lsu_rlast_o,
  input  logic              lsu_awvalid_i,
  output logic              lsu_awready_o,
  input  logic [AW-1:0]     lsu_awaddr_i,
  input  logic [2:0]        lsu_awsize_i,
  input  logic              lsu_wvalid_i,
  output logic              lsu_wready_o,
  input  logic [DW-1:0]     lsu_wdata_i,
  input  logic [DW/8-1:0]   lsu_wstrb_i,
  input  logic              lsu_wlast_i,
  output logic              lsu_bvalid_o,
  input  logic              lsu_bready_i,
  output logic [1:0]        lsu_bresp_o,
  output logic              m_arvalid_o,
  input  logic              m_arready_i,
  output logic [AW-1:0]     m_araddr_o,
  output logic [7:0]        m_arlen_o,
  output logic [2:0]        m_arsize_o,
  output logic [1:0]        m_arburst_o,
  input  logic              m_rvalid_i,
  output logic              m_rready_o,
  input  logic [DW-1:0]     m_rdata_i,
  input  logic [1:0]        m_rresp_i,
  input  logic              m_rlast_i,
  output logic              m_awvalid_o,
  input  logic              m_awready_i,
  output logic [AW-1:0]     m_awaddr_o,
  output logic [2:0]        m_awsize_o,
  output logic              m_wvalid_o,
  input  logic              m_wready_i,
  output logic [DW-1:0]     m_wdata_o,
  output logic [DW/8-1:0]   m_wstrb_o,
  output logic              m_wlast_o,
  input  logic              m_bvalid_i,
  output logic              m_bready_o,
  input  logic [1:0]        m_bresp_i
);

  // Everything idles at zero; only the owner's channels are connected
  always_comb begin
    m_arvalid_o   = 1'b0;
    m_araddr_o    = '0;
    m_arlen_o     = '0;
    m_arsize_o    = '0;
    m_arburst_o   = BURST_FIXED;
    m_rready_o    = 1'b0;
    m_awvalid_o   = 1'b0;
    m_awaddr_o    = '0;
    m_awsize_o    = '0;
    m_wvalid_o    = 1'b0;
    m_wdata_o     = '0;
    m_wstrb_o     = '0;
    m_wlast_o     = 1'b0;
    m_bready_o    = 1'b0;
    ifu_arready_o = 1'b0;
    ifu_rvalid_o  = 1'b0;
    ifu_rdata_o   = '0;
    ifu_rresp_o   = '0;
    ifu_rlast_o   = 1'b0;
    lsu_arready_o = 1'b0;
    lsu_rvalid_o  = 1'b0;
    lsu_rdata_o   = '0;
    lsu_rresp_o   = '0;
    lsu_rlast_o   = 1'b0;
    lsu_awready_o = 1'b0;
    lsu_wready_o  = 1'b0;
    lsu_bvalid_o  = 1'b0;
    lsu_bresp_o   = '0;
    unique case (state_i)
      IFU_RD: begin
        m_arvalid_o   = ifu_arvalid_i & ~ar_done_i;
        m_araddr_o    = ifu_araddr_i;
        m_arlen_o     = ifu_arlen_i;
        m_arsize_o    = ifu_arsize_i;
        m_arburst_o   = ar_burst(ifu_arlen_i);
        ifu_arready_o = m_arready_i & ~ar_done_i;
        ifu_rvalid_o  = m_rvalid_i;
        ifu_rdata_o   = m_rdata_i;
        ifu_rresp_o   = m_rresp_i;
        ifu_rlast_o   = m_rlast_i;
        m_rready_o    = ifu_rready_i;
      end
      LSU_RD: begin
        m_arvalid_o   = lsu_arvalid_i & ~ar_done_i;
        m_araddr_o    = lsu_araddr_i;
        m_arlen_o     = lsu_arlen_i;
        m_arsize_o    = lsu_arsize_i;
        m_arburst_o   = ar_burst(lsu_arlen_i);
        lsu_arready_o = m_arready_i & ~ar_done_i;
        lsu_rvalid_o  = m_rvalid_i;
        lsu_rdata_o   = m_rdata_i;
        lsu_rresp_o   = m_rresp_i;
        lsu_rlast_o   = m_rlast_i;
        m_rready_o    = lsu_rready_i;
      end
      LSU_WR: begin
        m_awvalid_o   = lsu_awvalid_i & ~aw_done_i;
        m_awaddr_o    = lsu_awaddr_i;
        m_awsize_o    = lsu_awsize_i;
        lsu_awready_o = m_awready_i & ~aw_done_i;
        m_wvalid_o    = lsu_wvalid_i;
        m_wdata_o     = lsu_wdata_i;
        m_wstrb_o     = lsu_wstrb_i;
        m_wlast_o     = lsu_wlast_i;
        lsu_wready_o  = m_wready_i;
        lsu_bvalid_o  = m_bvalid_i;
        lsu_bresp_o   = m_bresp_i;
        m_bready_o    = lsu_bready_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_25040111_arbiter.sv
// IFU/LSU to single AXI4 master arbiter (write > LSU rd > IFU rd).
// Define ARB_ROUND_ROBIN_EN to round-robin the two read masters.
module ysyx_25040111_arbiter
  import ysyx_25040111_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ifu_arvalid,
  output logic            ifu_arready,
  input  logic [AW-1:0]   ifu_araddr,
  input  logic [7:0]      ifu_arlen,
  input  logic [2:0]      ifu_arsize,
  output logic            ifu_rvalid,
  input  logic            ifu_rready,
  output logic [DW-1:0]   ifu_rdata,
  output logic [1:0]      ifu_rresp,
  output logic            ifu_rlast,
  input  logic            lsu_arvalid,
  output logic            lsu_arready,
  input  logic [AW-1:0]   lsu_araddr,
  input  logic [7:0]      lsu_arlen,
  input  logic [2:0]      lsu_arsize,
  output logic            lsu_rvalid,
  input  logic            lsu_rready,
  output logic [DW-1:0]   lsu_rdata,
  output logic [1:0]      lsu_rresp,
  output logic            lsu_rlast,
  input  logic            lsu_awvalid,
  output logic            lsu_awready,
  input  logic [AW-1:0]   lsu_awaddr,
  input  logic [2:0]      lsu_awsize,
  input  logic            lsu_wvalid,
  output logic            lsu_wready,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wstrb,
  input  logic            lsu_wlast,
  output logic            lsu_bvalid,
  input  logic            lsu_bready,
  output logic [1:0]      lsu_bresp,
  input  logic            io_master_awready,
  output logic            io_master_awvalid,
  output logic [AW-1:0]   io_master_awaddr,
  output logic [3:0]      io_master_awid,
  output logic [7:0]      io_master_awlen,
  output logic [2:0]      io_master_awsize,
  output logic [1:0]      io_master_awburst,
  input  logic            io_master_wready,
  output logic            io_master_wvalid,
  output logic [DW-1:0]   io_master_wdata,
  output logic [DW/8-1:0] io_master_wstrb,
  output logic            io_master_wlast,
  output logic            io_master_bready,
  input  logic            io_master_bvalid,
  input  logic [1:0]      io_master_bresp,
  input  logic            io_master_arready,
  output logic            io_master_arvalid,
  output logic [AW-1:0]   io_master_araddr,
  output logic [3:0]      io_master_arid,
  output logic [7:0]      io_master_arlen,
  output logic [2:0]      io_master_arsize,
  output logic [1:0]      io_master_arburst,
  output logic            io_master_rready,
  input  logic            io_master_rvalid,
  input  logic [1:0]      io_master_rresp,
  input  logic [DW-1:0]   io_master_rdata,
  input  logic            io_master_rlast
);

  arb_state_e state_q, state_d;
  logic       ar_done_q, ar_done_d;
  logic       aw_done_q, aw_done_d;
  logic [7:0] beat_q, beat_d;
  logic [7:0] len_q, len_d;
  logic       pick_lsu;
  logic       ar_hs, aw_hs, r_hs, b_hs, r_end;

  assign io_master_awid    = 4'b0;
  assign io_master_arid    = 4'b0;
  assign io_master_awlen   = 8'd0;
  assign io_master_awburst = BURST_FIXED;

  assign ar_hs = io_master_arvalid & io_master_arready;
  assign aw_hs = io_master_awvalid & io_master_awready;
  assign r_hs  = io_master_rvalid & io_master_rready;
  assign b_hs  = io_master_bvalid & io_master_bready;
  assign r_end = r_hs & (io_master_rlast | (beat_q == len_q));

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ifu_last_q;

  // Remember the last-served read master so it loses the next tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_ifu_last_q <= 1'b0;
    else if (state_q == IDLE && state_d == IFU_RD)
      rr_ifu_last_q <= 1'b1;
    else if (state_q == IDLE && state_d == LSU_RD)
      rr_ifu_last_q <= 1'b0;
  end

  assign pick_lsu = lsu_arvalid & (~ifu_arvalid | rr_ifu_last_q);
`else
  assign pick_lsu = lsu_arvalid;
`endif

  // State, address-accepted flags and R beat tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      beat_q    <= 8'd0;
      len_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
    end
  end

  // Arbitrate in IDLE, then hold the grant until the response ends
  always_comb begin
    state_d   = state_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    beat_d    = beat_q;
    len_d     = len_q;
    unique case (state_q)
      IDLE: begin
        ar_done_d = 1'b0;
        aw_done_d = 1'b0;
        beat_d    = 8'd0;
        if (lsu_awvalid)
          state_d = LSU_WR;
        else if (pick_lsu)
          state_d = LSU_RD;
        else if (ifu_arvalid)
          state_d = IFU_RD;
      end
      IFU_RD, LSU_RD: begin
        if (ar_hs) begin
          ar_done_d = 1'b1;
          len_d     = io_master_arlen;
        end
        if (r_hs)
          beat_d = beat_q + 8'd1;
        if (r_end)
          state_d = IDLE;
      end
      LSU_WR: begin
        if (aw_hs)
          aw_done_d = 1'b1;
        if (b_hs)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  ysyx_25040111_axi_mux #(.AW(AW), .DW(DW)) u_mux (
    .state_i       (state_q),
    .ar_done_i     (ar_done_q),
    .aw_done_i     (aw_done_q),
    .ifu_arvalid_i (ifu_arvalid),
    .ifu_arready_o (ifu_arready),
    .ifu_araddr_i  (ifu_araddr),
    .ifu_arlen_i   (ifu_arlen),
    .ifu_arsize_i  (ifu_arsize),
    .ifu_rvalid_o  (ifu_rvalid),
    .ifu_rready_i  (ifu_rready),
    .ifu_rdata_o   (ifu_rdata),
    .ifu_rresp_o   (ifu_rresp),
    .ifu_rlast_o   (ifu_rlast),
    .lsu_arvalid_i (lsu_arvalid),
    .lsu_arready_o (lsu_arready),
    .lsu_araddr_i  (lsu_araddr),
    .lsu_arlen_i   (lsu_arlen),
    .lsu_arsize_i  (lsu_arsize),
    .lsu_rvalid_o  (lsu_rvalid),
    .lsu_rready_i  (lsu_rready),
    .lsu_rdata_o   (lsu_rdata),
    .lsu_rresp_o   (lsu_rresp),
    .lsu_rlast_o   (lsu_rlast),
    .lsu_awvalid_i (lsu_awvalid),
    .lsu_awready_o (lsu_awready),
    .lsu_awaddr_i  (lsu_awaddr),
    .lsu_awsize_i  (lsu_awsize),
    .lsu_wvalid_i  (lsu_wvalid),
    .lsu_wready_o  (lsu_wready),
    .lsu_wdata_i   (lsu_wdata),
    .lsu_wstrb_i   (lsu_wstrb),
    .lsu_wlast_i   (lsu_wlast),
    .lsu_bvalid_o  (lsu_bvalid),
    .lsu_bready_i  (lsu_bready),
    .lsu_bresp_o   (lsu_bresp),
    .m_arvalid_o   (io_master_arvalid),
    .m_arready_i   (io_master_arready),
    .m_araddr_o    (io_master_araddr),
    .m_arlen_o     (io_master_arlen),
    .m_arsize_o    (io_master_arsize),
    .m_arburst_o   (io_master_arburst),
    .m_rvalid_i    (io_master_rvalid),
    .m_rready_o    (io_master_rready),
    .m_rdata_i     (io_master_rdata),
    .m_rresp_i     (io_master_rresp),
    .m_rlast_i     (io_master_rlast),
    .m_awvalid_o   (io_master_awvalid),
    .m_awready_i   (io_master_awready),
    .m_awaddr_o    (io_master_awaddr),
    .m_awsize_o    (io_master_awsize),
    .m_wvalid_o    (io_master_wvalid),
    .m_wready_i    (io_master_wready),
    .m_wdata_o     (io_master_wdata),
    .m_wstrb_o     (io_master_wstrb),
    .m_wlast_o     (io_master_wlast),
    .m_bvalid_i    (io_master_bvalid),
    .m_bready_o    (io_master_bready),
    .m_bresp_i     (io_master_bresp)
  );

endmodule

// File: tb/tb_ysyx_25040111_arbiter.sv
// Bench for the IFU/LSU AXI arbiter: vector table plus
// hand-written priority, reset and back-to-back sequences.
module tb_ysyx_25040111_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ifu_arvalid = 0, ifu_arready;
  logic [31:0] ifu_araddr = 0;
  logic [7:0]  ifu_arlen = 0;
  logic [2:0]  ifu_arsize = 0;
  logic        ifu_rvalid, ifu_rready = 0;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rlast;
  logic        lsu_arvalid = 0, lsu_arready;
  logic [31:0] lsu_araddr = 0;
  logic [7:0]  lsu_arlen = 0;
  logic [2:0]  lsu_arsize = 0;
  logic        lsu_rvalid, lsu_rready = 0;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_rlast;
  logic        lsu_awvalid = 0, lsu_awready;
  logic [31:0] lsu_awaddr = 0;
  logic [2:0]  lsu_awsize = 0;
  logic        lsu_wvalid = 0, lsu_wready;
  logic [31:0] lsu_wdata = 0;
  logic [3:0]  lsu_wstrb = 0;
  logic        lsu_wlast = 0;
  logic        lsu_bvalid, lsu_bready = 0;
  logic [1:0]  lsu_bresp;
  logic        m_awready = 0, m_awvalid;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awid;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_wready = 0, m_wvalid;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_bready, m_bvalid = 0;
  logic [1:0]  m_bresp = 0;
  logic        m_arready = 0, m_arvalid;
  logic [31:0] m_araddr;
  logic [3:0]  m_arid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rready, m_rvalid = 0;
  logic [1:0]  m_rresp = 0;
  logic [31:0] m_rdata = 0;
  logic        m_rlast = 0;

  ysyx_25040111_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen),
    .ifu_arsize(ifu_arsize), .ifu_rvalid(ifu_rvalid),
    .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_araddr(lsu_araddr), .lsu_arlen(lsu_arlen),
    .lsu_arsize(lsu_arsize), .lsu_rvalid(lsu_rvalid),
    .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
    .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast),
    .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_awaddr(lsu_awaddr), .lsu_awsize(lsu_awsize),
    .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_wlast(lsu_wlast), .lsu_bvalid(lsu_bvalid),
    .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp),
    .io_master_awready(m_awready), .io_master_awvalid(m_awvalid),
    .io_master_awaddr(m_awaddr), .io_master_awid(m_awid),
    .io_master_awlen(m_awlen), .io_master_awsize(m_awsize),
    .io_master_awburst(m_awburst), .io_master_wready(m_wready),
    .io_master_wvalid(m_wvalid), .io_master_wdata(m_wdata),
    .io_master_wstrb(m_wstrb), .io_master_wlast(m_wlast),
    .io_master_bready(m_bready), .io_master_bvalid(m_bvalid),
    .io_master_bresp(m_bresp), .io_master_arready(m_arready),
    .io_master_arvalid(m_arvalid), .io_master_araddr(m_araddr),
    .io_master_arid(m_arid), .io_master_arlen(m_arlen),
    .io_master_arsize(m_arsize), .io_master_arburst(m_arburst),
    .io_master_rready(m_rready), .io_master_rvalid(m_rvalid),
    .io_master_rresp(m_rresp), .io_master_rdata(m_rdata),
    .io_master_rlast(m_rlast)
  );

  always #5 clk = ~clk;

  // who: 0 = IFU read, 1 = LSU read, 2 = LSU write
  typedef struct {
    int          who;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [1:0]  burst;
  } vec_t;

  typedef struct {
    int          who;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_t;

  exp_t sb[$];
  vec_t vt[6];
  int   n_cmp = 0;
  int   n_err = 0;
  int   last_rd = 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic sb_check(input int who, input logic [31:0] d,
                          input logic [1:0] r, input logic l);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_resp", 64'(who), 64'hFF);
    end else begin
      e = sb.pop_front();
      chk("sb_owner", 64'(who), 64'(e.who));
      chk("sb_data", d, e.data);
      chk("sb_resp", r, e.resp);
      chk("sb_last", l, e.last);
    end
  endtask

  // Response monitor, sampled mid-cycle after the driver settles
  always @(negedge clk) begin
    #2;
    if (ifu_rvalid && ifu_rready)
      sb_check(0, ifu_rdata, ifu_rresp, ifu_rlast);
    if (lsu_rvalid && lsu_rready)
      sb_check(1, lsu_rdata, lsu_rresp, lsu_rlast);
    if (lsu_bvalid && lsu_bready)
      sb_check(2, 32'd0, lsu_bresp, 1'b1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_grant(output int k);
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!(m_arvalid || m_awvalid) && k < 8);
    chk("grant_seen", m_arvalid | m_awvalid, 1);
  endtask

  // Accept AR, then drive nb R beats (last on beat len)
  task automatic serve_read(input int who, input logic [7:0] len,
                            input logic [31:0] d,
                            input logic [1:0] resp,
                            input bit drop, input int nb);
    exp_t e;
    m_arready = 1;
    #1;
    chk("ar_ready_pass",
        (who == 0) ? ifu_arready : lsu_arready, 1);
    @(negedge clk);
    m_arready = 0;
    #1;
    chk("ar_once", m_arvalid, 0);
    if (drop) begin
      if (who == 0) ifu_arvalid = 0;
      else lsu_arvalid = 0;
    end
    last_rd = who;
    for (int i = 0; i < nb; i++) begin
      m_rvalid = 1;
      m_rdata  = d + 32'(i);
      m_rresp  = resp;
      m_rlast  = (i == int'(len));
      e.who = who;
      e.data = d + 32'(i);
      e.resp = resp;
      e.last = (i == int'(len));
      sb.push_back(e);
      @(negedge clk);
    end
    m_rvalid = 0;
    m_rlast  = 0;
  endtask

  task automatic do_read(input vec_t v);
    int k;
    @(negedge clk);
    if (v.who == 0) begin
      ifu_arvalid = 1; ifu_araddr = v.addr;
      ifu_arlen = v.len; ifu_arsize = v.size;
    end else begin
      lsu_arvalid = 1; lsu_araddr = v.addr;
      lsu_arlen = v.len; lsu_arsize = v.size;
    end
    #1;
    chk("rd_pregrant", m_arvalid, 0);
    wait_grant(k);
    chk("rd_latency", 64'(k), 1);
    chk("araddr", m_araddr, v.addr);
    chk("arlen", m_arlen, v.len);
    chk("arsize", m_arsize, v.size);
    chk("arburst", m_arburst, v.burst);
    chk("arid", m_arid, 0);
    serve_read(v.who, v.len, v.data, v.resp, 1, int'(v.len) + 1);
    #1;
    chk("rd_idle_addr", m_araddr, 0);
    chk("rd_idle_rready", m_rready, 0);
  endtask

  task automatic do_write(input vec_t v);
    int k;
    exp_t e;
    @(negedge clk);
    lsu_awvalid = 1; lsu_awaddr = v.addr; lsu_awsize = v.size;
    lsu_wvalid = 1; lsu_wdata = v.data;
    lsu_wstrb = v.strb; lsu_wlast = 1;
    #1;
    chk("wr_pregrant", m_awvalid, 0);
    wait_grant(k);
    chk("wr_latency", 64'(k), 1);
    chk("awaddr", m_awaddr, v.addr);
    chk("awsize", m_awsize, v.size);
    chk("awlen", m_awlen, 0);
    chk("wdata", m_wdata, v.data);
    chk("wstrb", m_wstrb, v.strb);
    chk("wvalid_wlast", {m_wvalid, m_wlast}, 2'b11);
    chk("aw_wait_ready", lsu_awready, 0);
    m_awready = 1;
    m_wready  = 1;
    #1;
    chk("aw_w_ready_pass", {lsu_awready, lsu_wready}, 2'b11);
    @(negedge clk);
    m_awready = 0;
    m_wready  = 0;
    #1;
    chk("aw_once", m_awvalid, 0);
    lsu_awvalid = 0; lsu_wvalid = 0; lsu_wlast = 0;
    @(negedge clk);
    m_bvalid = 1;
    m_bresp  = v.resp;
    e.who = 2; e.data = 0; e.resp = v.resp; e.last = 1;
    sb.push_back(e);
    @(negedge clk);
    m_bvalid = 0;
    #1;
    chk("wr_idle_addr", m_awaddr, 0);
    chk("wr_idle_data", m_wdata, 0);
  endtask

  initial begin
    int k;
    int exp_who;
    vt[0] = '{0, 32'h3000_0000, 8'd0, 3'd2, 32'hDEAD_BEEF,
              4'h0, 2'b00, 2'b00};
    vt[1] = '{1, 32'h8000_0010, 8'd0, 3'd2, 32'h1234_5678,
              4'h0, 2'b10, 2'b00};
    vt[2] = '{2, 32'h8000_0100, 8'd0, 3'd2, 32'h0000_1234,
              4'b0011, 2'b00, 2'b00};
    vt[3] = '{0, 32'h3000_0040, 8'd3, 3'd2, 32'hA000_0000,
              4'h0, 2'b00, 2'b01};
    vt[4] = '{2, 32'h8000_0204, 8'd0, 3'd1, 32'hCAFE_F00D,
              4'b1100, 2'b10, 2'b00};
    vt[5] = '{1, 32'h8000_0300, 8'd1, 3'd2, 32'h5555_0000,
              4'h0, 2'b00, 2'b01};
    ifu_rready = 1;
    lsu_rready = 1;
    lsu_bready = 1;

    @(negedge clk);
    #1;
    chk("rst_valids",
        {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 0);
    chk("rst_readies",
        {ifu_arready, lsu_arready, lsu_awready, lsu_wready}, 0);
    chk("rst_addr", m_araddr, 0);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 6; i++) begin
      if (vt[i].who == 2) do_write(vt[i]);
      else do_read(vt[i]);
    end

    // Same-cycle IFU and LSU reads: LSU first, IFU held off
    @(negedge clk);
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0080;
    ifu_arlen = 0; ifu_arsize = 3'd2;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0400;
    lsu_arlen = 0; lsu_arsize = 3'd2;
    wait_grant(k);
`ifdef ARB_ROUND_ROBIN_EN
    exp_who = (last_rd == 0) ? 1 : 0;
`else
    exp_who = 1;
`endif
    chk("pri_first_addr", m_araddr,
        (exp_who == 1) ? 32'h8000_0400 : 32'h3000_0080);
    chk("pri_loser_ready",
        (exp_who == 1) ? ifu_arready : lsu_arready, 0);
    serve_read(exp_who, 8'd0, 32'h0BAD_0001, 2'b00, 1, 1);
    #1;
    chk("pri_pending_idle", m_arvalid, 0);
    wait_grant(k);
    chk("pri_second_lat", 64'(k), 1);
    chk("pri_second_addr", m_araddr,
        (exp_who == 1) ? 32'h3000_0080 : 32'h8000_0400);
    serve_read(1 - exp_who, 8'd0, 32'h0BAD_0002, 2'b00, 1, 1);

    // IFU burst interrupted by reset after two beats
    @(negedge clk);
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0100;
    ifu_arlen = 8'd3; ifu_arsize = 3'd2;
    wait_grant(k);
    chk("burst_arburst", m_arburst, 2'b01);
    serve_read(0, 8'd3, 32'h7700_0000, 2'b00, 1, 2);
    reset = 1;
    #1;
    chk("arst_valids",
        {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 0);
    chk("arst_readies",
        {ifu_arready, lsu_arready, lsu_awready, lsu_wready}, 0);
    chk("arst_addr", m_araddr, 0);
    last_rd = 1;
    @(negedge clk);
    reset = 0;
    do_read(vt[0]);

    // Both read masters requesting continuously
    @(negedge clk);
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0200;
    ifu_arlen = 0; ifu_arsize = 3'd2;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0500;
    lsu_arlen = 0; lsu_arsize = 3'd2;
    for (int g = 0; g < 4; g++) begin
      wait_grant(k);
      chk("cont_latency", 64'(k), 1);
`ifdef ARB_ROUND_ROBIN_EN
      exp_who = (last_rd == 0) ? 1 : 0;
`else
      exp_who = 1;
`endif
      chk("cont_grant_addr", m_araddr,
          (exp_who == 1) ? 32'h8000_0500 : 32'h3000_0200);
      serve_read(exp_who, 8'd0, 32'hC000_0000 + 32'(g),
                 2'b00, 0, 1);
    end
    ifu_arvalid = 0;
    lsu_arvalid = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("end_idle", m_arvalid | m_awvalid, 0);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
